// File: rtl/regfile_write_arbiter.sv
// Write-port owner for an N-word register file: init sweep to INIT_VALUE, then
// arbitrates requesters A/B. Define ARB_ROUND_ROBIN_EN for alternating priority.
module regfile_write_arbiter #(
  parameter int             M          = 4,
  parameter int             N          = 16,
  parameter int             W          = 8,
  parameter logic [W-1:0]   INIT_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         req_a,
  input  logic [M-1:0] addr_a,
  input  logic [W-1:0] data_a,
  output logic         ready_a,
  input  logic         req_b,
  input  logic [M-1:0] addr_b,
  input  logic [W-1:0] data_b,
  output logic         ready_b,
  output logic         init_done,
  output logic         rf_wr_enable,
  output logic [M-1:0] rf_wr_addr,
  output logic [W-1:0] rf_din
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   cnt_q, cnt_d;
  logic           init_done_q, init_done_d;
  logic           wr_en_q, wr_en_d;
  logic [M-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]   din_q, din_d;
  logic           grant_a, grant_b;
  logic           prio_a;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q = 0 favours A, 1 favours B
  logic           ptr_q, ptr_d;
  assign prio_a = ~ptr_q;
`else
  assign prio_a = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    din_d       = din_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      S_INIT: begin
        if (clr) begin
          cnt_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          din_d     = INIT_VALUE;
          if (cnt_q == M'(N - 1)) begin
            state_d     = S_RUN;
            cnt_d       = '0;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + M'(1);
          end
        end
      end
      S_RUN: begin
        if (clr) begin
          state_d     = S_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else begin
          grant_a = req_a & (prio_a | ~req_b);
          grant_b = req_b & ~grant_a;
          if (grant_a) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_a;
            din_d     = data_a;
          end else if (grant_b) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_b;
            din_d     = data_b;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (grant_a | grant_b) ptr_d = ~ptr_q;
`endif
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Reset is synchronous, so a request seen while rst_n is low never completes
  assign ready_a = grant_a & rst_n;
  assign ready_b = grant_b & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      din_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      din_q       <= din_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign init_done    = init_done_q;
  assign rf_wr_enable = wr_en_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_din       = din_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table for RUN traffic plus hand-written
// reset/clear sequences; expected writes flow through a scoreboard queue.
module tb_regfile_write_arbiter;

  localparam int M = 4;
  localparam int N = 16;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, clr;
  logic         req_a, req_b;
  logic [M-1:0] addr_a, addr_b;
  logic [W-1:0] data_a, data_b;
  logic         ready_a, ready_b;
  logic         init_done, rf_wr_enable;
  logic [M-1:0] rf_wr_addr;
  logic [W-1:0] rf_din;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.M(M), .N(N), .W(W), .INIT_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ready_a(ready_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ready_b(ready_b),
    .init_done(init_done), .rf_wr_enable(rf_wr_enable),
    .rf_wr_addr(rf_wr_addr), .rf_din(rf_din)
  );

  typedef struct {
    logic         en;
    logic [M-1:0] addr;
    logic [W-1:0] data;
    logic         done;
  } wr_t;

  typedef struct {
    logic         ra;
    logic [M-1:0] aa;
    logic [W-1:0] da;
    logic         rb;
    logic [M-1:0] ab;
    logic [W-1:0] db;
    logic         xa;
    logic         xb;
  } vec_t;

  wr_t          exp_q[$];
  vec_t         vt[10];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [M-1:0] last_addr = '0;
  logic [W-1:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs hold their last address/data when no write is registered
  task automatic push(input logic en, input logic [M-1:0] a, input logic [W-1:0] d, input logic done);
    wr_t r;
    if (en) begin
      last_addr = a;
      last_data = d;
    end
    r.en   = en;
    r.addr = last_addr;
    r.data = last_data;
    r.done = done;
    exp_q.push_back(r);
  endtask

  task automatic push_reset();
    last_addr = '0;
    last_data = '0;
    push(1'b0, '0, '0, 1'b0);
  endtask

  // Called just after a rising edge: drive, check ready, clock, check registered outputs
  task automatic step(input string tag, input logic rn, input logic c,
                      input logic ra, input logic [M-1:0] aa, input logic [W-1:0] da,
                      input logic rb, input logic [M-1:0] ab, input logic [W-1:0] db,
                      input logic xa, input logic xb);
    wr_t r;
    rst_n = rn; clr = c;
    req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db;
    #2;
    chk({tag, ".ready_a"}, 32'(ready_a), 32'(xa));
    chk({tag, ".ready_b"}, 32'(ready_b), 32'(xb));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      r = exp_q.pop_front();
      chk({tag, ".wr_enable"}, 32'(rf_wr_enable), 32'(r.en));
      chk({tag, ".wr_addr"},   32'(rf_wr_addr),   32'(r.addr));
      chk({tag, ".din"},       32'(rf_din),       32'(r.data));
      chk({tag, ".init_done"}, 32'(init_done),    32'(r.done));
    end
    $display("%s rst_n=%b clr=%b ra=%b rb=%b rdy=%b%b -> en=%b addr=%0d din=%02h done=%b",
             tag, rn, c, ra, rb, ready_a, ready_b, rf_wr_enable, rf_wr_addr, rf_din, init_done);
  endtask

  // Sweep of cnt cycles starting at address 0; B may hold a request throughout
  task automatic sweep(input string tag, input int cnt, input logic rb,
                       input logic [M-1:0] ab, input logic [W-1:0] db);
    for (int i = 0; i < cnt; i++) begin
      push(1'b1, M'(i), 8'h00, (i == N - 1));
      step($sformatf("%s[%0d]", tag, i), 1'b1, 1'b0, 1'b0, '0, '0, rb, ab, db, 1'b0, 1'b0);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    if (v.xa)      push(1'b1, v.aa, v.da, 1'b1);
    else if (v.xb) push(1'b1, v.ab, v.db, 1'b1);
    else           push(1'b0, '0, '0, 1'b1);
    step(tag, 1'b1, 1'b0, v.ra, v.aa, v.da, v.rb, v.ab, v.db, v.xa, v.xb);
  endtask

  initial begin
    vt[0] = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h50, 1'b0, 1'b1};
    vt[3] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h60, 1'b0, 1'b1};
    vt[4] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h70, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      vt[5 + k] = '{1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, (k % 2 == 0), (k % 2 == 1)};
`else
      vt[5 + k] = '{1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0};
`endif
    end
    vt[9] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; clr = 1'b0;
    req_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; addr_b = '0; data_b = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      push_reset();
      step($sformatf("reset[%0d]", i), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    sweep("init", N, 1'b0, '0, '0);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec[%0d]", i), vt[i]);

    // clr beats a pending B request; B is served only after the new sweep
    push(1'b0, '0, '0, 1'b0);
    step("clr_b", 1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 4'd9, 8'h99, 1'b0, 1'b0);
    sweep("clr_sweep", N, 1'b1, 4'd9, 8'h99);
    push(1'b1, 4'd9, 8'h99, 1'b1);
    step("b_after", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 4'd9, 8'h99, 1'b0, 1'b1);
    push(1'b0, '0, '0, 1'b1);
    step("idle", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Reset in the middle of a sweep, with a request that must be dropped
    push(1'b0, '0, '0, 1'b0);
    step("clr_run", 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    sweep("part", 7, 1'b0, '0, '0);
    push_reset();
    step("rst_mid", 1'b0, 1'b0, 1'b1, 4'd8, 8'h88, 1'b0, '0, '0, 1'b0, 1'b0);
    sweep("resweep", N, 1'b0, '0, '0);
    push(1'b1, 4'd4, 8'h44, 1'b1);
    step("a_after", 1'b1, 1'b0, 1'b1, 4'd4, 8'h44, 1'b0, '0, '0, 1'b1, 1'b0);
    push(1'b0, '0, '0, 1'b1);
    step("tail", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
